// File: rtl/uart_line_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_line_tx
//  Purpose  : Byte-stream UART transmitter. Bytes enter through a valid/ready
//             handshake, wait in a small FIFO and are sent as 8N1 or 8N2
//             frames at a fixed number of clocks per bit. Back-to-back
//             frames have no idle gap between them.
//  Ports    : theclk      - clock, all state changes on the rising edge
//             theresetn   - asynchronous active-low reset
//             in_data     - byte to send
//             in_valid    - in_data is valid
//             in_ready    - FIFO can take a byte (level below FIFO_DEPTH)
//             tx          - serial line, idle high
//             busy        - frame in progress or FIFO non-empty
//             fifo_level  - current FIFO occupancy
//             tx_done     - one-cycle pulse after each frame
//             line_done   - one-cycle pulse after a frame carrying 0x0A/0x0D
//  Revision : 1.0  initial release
// ============================================================================
module uart_line_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          theclk,
  input  logic                          theresetn,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_done,
  output logic                          line_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Byte FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  // in_ready comes only from the registered level, so a full FIFO refuses a
  // write even when the FSM pops in the same cycle.
  assign in_ready   = (level != FULL_LEVEL);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (level == '0);
  assign fifo_level = level;

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge theclk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge theclk or negedge theresetn) begin
    if (!theresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [2:0]    idx;
  logic [2:0]    idx_nx;
  logic [7:0]    cur;
  logic [7:0]    cur_nx;
  logic          tx_nx;
  logic          done_nx;
  logic          line_nx;

  assign busy = (state != IDLE) | ~fifo_empty;

  // tx is registered, so tx_nx is the line level for the state being
  // entered; this gives the one-edge write-to-start-bit latency.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    cur_nx   = cur;
    tx_nx    = tx;
    done_nx  = 1'b0;
    line_nx  = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        tx_nx  = 1'b1;
        cnt_nx = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          cur_nx   = mem[rd_ptr];
          idx_nx   = '0;
          state_nx = START;
          tx_nx    = 1'b0;
        end
      end
      START: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = DATA;
          tx_nx    = cur[0];
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            idx_nx = idx + 3'd1;
            tx_nx  = cur[idx_nx];
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == STOP_LAST) begin
          cnt_nx  = '0;
          done_nx = 1'b1;
          line_nx = (cur == 8'h0A) || (cur == 8'h0D);
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            pop      = 1'b1;
            cur_nx   = mem[rd_ptr];
            idx_nx   = '0;
            state_nx = START;
            tx_nx    = 1'b0;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge theclk or negedge theresetn) begin
    if (!theresetn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      cur       <= '0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
      line_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      cur       <= cur_nx;
      tx        <= tx_nx;
      tx_done   <= done_nx;
      line_done <= line_nx;
    end
  end

endmodule
`default_nettype wire
